// File: rtl/crc16_frame_ctrl.sv
// crc16_frame_ctrl: sequencer for the serial CRC-16 check path.
// Accepts 32-bit frame words over valid/ready and shifts each word MSB-first,
// one bit per clock, through a CRC-16 LFSR (poly 0x1021, non-reflected).
// At end of frame it holds the remainder and verdict on a result handshake.
// Build option: define CRC_SEED_ONES_EN for a 16'hFFFF seed (CCITT-FALSE);
// when it is undefined the seed is 16'h0000 (XMODEM).
`timescale 1ns/1ps

module crc16_frame_ctrl #(
    parameter int MAX_WORDS = 64,
    parameter int CW        = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_data,
    input  logic          in_last,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [15:0]   res_crc,
    output logic          res_ok,
    output logic          res_ovf,
    output logic [CW-1:0] res_words,
    output logic          busy
);

`ifdef CRC_SEED_ONES_EN
    localparam logic [15:0] SEED = 16'hFFFF;
`else
    localparam logic [15:0] SEED = 16'h0000;
`endif

    localparam logic [CW-1:0] WMAX = CW'(MAX_WORDS);
    localparam logic [CW-1:0] WSAT = CW'(MAX_WORDS + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        WAIT   = 2'd2,
        RESULT = 2'd3
    } state_t;

    state_t        state;
    logic [31:0]   sreg;
    logic [15:0]   lfsr;
    logic [15:0]   lfsr_next;
    logic [4:0]    bcnt;
    logic          last_q;
    logic [CW-1:0] wcnt;
    logic          ovf;
    logic          fb;

    // One LFSR step: feed the current MSB of the shift register.
    always_comb begin
        fb        = sreg[31] ^ lfsr[15];
        lfsr_next = {lfsr[14:12], lfsr[11] ^ fb, lfsr[10:5], lfsr[4] ^ fb, lfsr[3:0], fb};
    end

    // Frame sequencer with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            sreg      <= '0;
            lfsr      <= SEED;
            bcnt      <= '0;
            last_q    <= 1'b0;
            wcnt      <= '0;
            ovf       <= 1'b0;
            in_ready  <= 1'b0;
            res_valid <= 1'b0;
            res_crc   <= '0;
            res_ok    <= 1'b0;
            res_ovf   <= 1'b0;
            res_words <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        sreg     <= in_data;
                        last_q   <= in_last;
                        wcnt     <= CW'(1);
                        ovf      <= 1'b0;
                        lfsr     <= SEED;
                        bcnt     <= 5'd31;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                SHIFT: begin
                    lfsr <= lfsr_next;
                    sreg <= {sreg[30:0], 1'b0};
                    bcnt <= bcnt - 5'd1;
                    if (bcnt == 5'd0) begin
                        if (last_q) begin
                            res_valid <= 1'b1;
                            res_crc   <= lfsr_next;
                            res_ok    <= (lfsr_next == 16'h0000) && !ovf;
                            res_ovf   <= ovf;
                            res_words <= wcnt;
                            state     <= RESULT;
                        end else begin
                            in_ready <= 1'b1;
                            state    <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (in_valid && in_ready) begin
                        sreg     <= in_data;
                        last_q   <= in_last;
                        bcnt     <= 5'd31;
                        in_ready <= 1'b0;
                        // wcnt is the pre-increment count, so >= WMAX means the new word is past the limit
                        if (wcnt >= WMAX) begin
                            ovf <= 1'b1;
                        end
                        if (wcnt != WSAT) begin
                            wcnt <= wcnt + CW'(1);
                        end
                        state <= SHIFT;
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crc16_frame_ctrl.sv
// Directed self-checking bench for crc16_frame_ctrl.
// A second instance with MAX_WORDS=2 shares all inputs and runs in lockstep
// with the default instance; it is inspected in the overflow scenario.
`timescale 1ns/1ps

module tb_crc16_frame_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_last;
    logic        res_ready;

    logic        in_ready,  res_valid,  res_ok,  res_ovf,  busy;
    logic [15:0] res_crc;
    logic [6:0]  res_words;

    logic        in_ready2, res_valid2, res_ok2, res_ovf2, busy2;
    logic [15:0] res_crc2;
    logic [1:0]  res_words2;

    int tests;
    int fails;

    crc16_frame_ctrl #(.MAX_WORDS(64), .CW(7)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .res_valid(res_valid), .res_ready(res_ready), .res_crc(res_crc), .res_ok(res_ok),
        .res_ovf(res_ovf), .res_words(res_words), .busy(busy)
    );

    crc16_frame_ctrl #(.MAX_WORDS(2), .CW(2)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data), .in_last(in_last),
        .res_valid(res_valid2), .res_ready(res_ready), .res_crc(res_crc2), .res_ok(res_ok2),
        .res_ovf(res_ovf2), .res_words(res_words2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one word and complete its handshake (bounded wait for in_ready).
    task automatic send(input logic [31:0] d, input logic l);
        int k;
        k = 0;
        while (in_ready !== 1'b1 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        tests++;
        if (k >= 200) begin
            fails++;
            $display("FAIL send_timeout: in_ready=%b, required 1 within 200 cycles", in_ready);
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    // Count edges after a handshake until in_ready or res_valid rises.
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!(in_ready === 1'b1 || res_valid === 1'b1) && n < 100);
        tests++;
        if (n >= 100) begin
            fails++;
            $display("FAIL done_timeout: no in_ready/res_valid after %0d cycles", n);
        end
    endtask

    // Accept the pending result and check the return to IDLE.
    task automatic consume();
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        tests++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL consume: res_valid=%b in_ready=%b busy=%b, required 0 1 0", res_valid, in_ready, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (in_ready !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctrl: in_ready=%b res_valid=%b busy=%b, required 0 0 0", in_ready, res_valid, busy);
        end
        tests++;
        if (res_crc !== 16'h0000 || res_ok !== 1'b0 || res_ovf !== 1'b0 || res_words !== 7'd0) begin
            fails++;
            $display("FAIL reset_res: crc=%h ok=%b ovf=%b words=%0d, required 0000 0 0 0", res_crc, res_ok, res_ovf, res_words);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: in_ready=%b busy=%b, required 1 0", in_ready, busy);
        end
    endtask

    task automatic test_single_word();
        int n;
        send(32'h0000_0001, 1'b1);
        tests++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL single_busy: busy=%b in_ready=%b, required 1 0", busy, in_ready);
        end
        wait_done(n);
        tests++;
        if (n !== 32 || res_valid !== 1'b1) begin
            fails++;
            $display("FAIL single_latency: edges=%0d res_valid=%b, required 32 1", n, res_valid);
        end
        tests++;
        if (res_crc !== 16'h1021 || res_ok !== 1'b0 || res_ovf !== 1'b0 || res_words !== 7'd1) begin
            fails++;
            $display("FAIL single_res: crc=%h ok=%b ovf=%b words=%0d, required 1021 0 0 1", res_crc, res_ok, res_ovf, res_words);
        end
        consume();
    endtask

    task automatic test_appended_crc();
        int n;
        send(32'h0001_1021, 1'b1);
        wait_done(n);
        tests++;
        if (res_valid !== 1'b1 || res_crc !== 16'h0000 || res_ok !== 1'b1 || res_words !== 7'd1) begin
            fails++;
            $display("FAIL appended_res: valid=%b crc=%h ok=%b words=%0d, required 1 0000 1 1", res_valid, res_crc, res_ok, res_words);
        end
        consume();
    endtask

    task automatic test_wait_stall();
        int n;
        int bad;
        // Spec vector: zero word, 10-cycle stall, then data with appended CRC.
        send(32'h0000_0000, 1'b0);
        wait_done(n);
        tests++;
        if (n !== 32 || in_ready !== 1'b1 || res_valid !== 1'b0) begin
            fails++;
            $display("FAIL wait_entry: edges=%0d in_ready=%b res_valid=%b, required 32 1 0", n, in_ready, res_valid);
        end
        bad = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (in_ready !== 1'b1 || busy !== 1'b1 || res_valid !== 1'b0 || dut.lfsr !== 16'h0000) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL wait_stall_zero: %0d bad cycles, required 0", bad);
        end
        send(32'h0001_1021, 1'b1);
        wait_done(n);
        tests++;
        if (res_crc !== 16'h0000 || res_ok !== 1'b1 || res_words !== 7'd2) begin
            fails++;
            $display("FAIL wait_res: crc=%h ok=%b words=%0d, required 0000 1 2", res_crc, res_ok, res_words);
        end
        consume();
        // Nonzero LFSR state (0x1021) must hold through a stall.
        send(32'h0000_0001, 1'b0);
        wait_done(n);
        bad = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (in_ready !== 1'b1 || dut.lfsr !== 16'h1021) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL wait_stall_hold: %0d bad cycles, lfsr=%h, required 0 and 1021", bad, dut.lfsr);
        end
        send(32'h1021_0000, 1'b1);
        wait_done(n);
        tests++;
        if (res_crc !== 16'h0000 || res_ok !== 1'b1 || res_words !== 7'd2) begin
            fails++;
            $display("FAIL wait_hold_res: crc=%h ok=%b words=%0d, required 0000 1 2", res_crc, res_ok, res_words);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        int n1;
        int n2;
        send(32'h0000_0001, 1'b0);
        wait_done(n1);
        send(32'h1021_0000, 1'b1);
        wait_done(n2);
        tests++;
        if (n1 !== 32 || n2 !== 32) begin
            fails++;
            $display("FAIL b2b_latency: edges=%0d,%0d, required 32,32", n1, n2);
        end
        tests++;
        if (res_valid !== 1'b1 || res_crc !== 16'h0000 || res_ok !== 1'b1 || res_words !== 7'd2) begin
            fails++;
            $display("FAIL b2b_res: valid=%b crc=%h ok=%b words=%0d, required 1 0000 1 2", res_valid, res_crc, res_ok, res_words);
        end
        consume();
    endtask

    task automatic test_result_hold();
        int n;
        int bad;
        send(32'h0000_0001, 1'b1);
        wait_done(n);
        // Offer the next frame while the result is pending; it must not be taken.
        in_valid = 1'b1;
        in_data  = 32'h0001_1021;
        in_last  = 1'b1;
        bad = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (res_valid !== 1'b1 || res_crc !== 16'h1021 || res_ok !== 1'b0 ||
                res_words !== 7'd1 || in_ready !== 1'b0 || busy !== 1'b1) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL hold_stable: %0d bad cycles, required 0", bad);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        tests++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL hold_release: res_valid=%b in_ready=%b busy=%b, required 0 1 0", res_valid, in_ready, busy);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        tests++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL hold_next_accept: in_ready=%b busy=%b, required 0 1", in_ready, busy);
        end
        wait_done(n);
        tests++;
        if (n !== 32 || res_crc !== 16'h0000 || res_ok !== 1'b1) begin
            fails++;
            $display("FAIL hold_next_res: edges=%0d crc=%h ok=%b, required 32 0000 1", n, res_crc, res_ok);
        end
        consume();
    endtask

    task automatic test_overflow();
        int n;
        send(32'h0000_0000, 1'b0);
        wait_done(n);
        send(32'h0000_0000, 1'b0);
        wait_done(n);
        send(32'h0000_0000, 1'b1);
        wait_done(n);
        tests++;
        if (res_valid2 !== 1'b1 || res_ovf2 !== 1'b1 || res_ok2 !== 1'b0 ||
            res_crc2 !== 16'h0000 || res_words2 !== 2'd3) begin
            fails++;
            $display("FAIL ovf_small: valid=%b ovf=%b ok=%b crc=%h words=%0d, required 1 1 0 0000 3",
                     res_valid2, res_ovf2, res_ok2, res_crc2, res_words2);
        end
        tests++;
        if (res_ovf !== 1'b0 || res_ok !== 1'b1 || res_words !== 7'd3) begin
            fails++;
            $display("FAIL ovf_default: ovf=%b ok=%b words=%0d, required 0 1 3", res_ovf, res_ok, res_words);
        end
        consume();
    endtask

    task automatic test_reset_mid_frame();
        int n;
        int bad;
        send(32'h0000_0001, 1'b1);
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        tests++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || res_valid !== 1'b0 || res_crc !== 16'h0000 ||
            res_ok !== 1'b0 || res_ovf !== 1'b0 || res_words !== 7'd0) begin
            fails++;
            $display("FAIL midrst_outputs: rdy=%b busy=%b val=%b crc=%h ok=%b ovf=%b words=%0d, required all 0",
                     in_ready, busy, res_valid, res_crc, res_ok, res_ovf, res_words);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        bad = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (res_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL midrst_no_result: %0d bad cycles, required 0", bad);
        end
        send(32'h0000_0001, 1'b1);
        wait_done(n);
        tests++;
`ifdef CRC_SEED_ONES_EN
        if (res_valid !== 1'b1 || res_crc === 16'h0000 || res_crc === 16'h1021) begin
            fails++;
            $display("FAIL midrst_frame: valid=%b crc=%h, required 1 and crc not 0000/1021", res_valid, res_crc);
        end
`else
        if (res_valid !== 1'b1 || res_crc !== 16'h1021 || res_words !== 7'd1) begin
            fails++;
            $display("FAIL midrst_frame: valid=%b crc=%h words=%0d, required 1 1021 1", res_valid, res_crc, res_words);
        end
`endif
        consume();
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        res_ready = 1'b0;
        test_reset();
        test_single_word();
        test_appended_crc();
        test_wait_stall();
        test_back_to_back();
        test_result_hold();
        test_overflow();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
